data_mem_hs: RTL and testbench
==============================

// Module: data_mem_hs
// PURPOSE
//  Parametrised data memory for the RISC-16 LOAD/STORE path. Replaces the flat
//  combinational-read RAM with a request/response port, byte-lane writes,
//  configurable wait states and out-of-range error reporting.
//  Sits between the MEM-stage control and the register write-back mux.
//  Enables slower, larger on-chip memories without changing the core protocol.
// PARAMETERS
//  DATA_W       16    word width in bits; must be a multiple of 8
//  ADDR_W       16    word-address width
//  DEPTH        1024  implemented words; valid addresses are 0..DEPTH-1, DEPTH <= 2**ADDR_W
//  WAIT_STATES  1     extra cycles before the array access; legal range 0..7
// PORTS
//  clk     in   1         system clock; all state changes on the rising edge
//  rst_n   in   1         asynchronous, active-low reset
//  req     in   1         access request; sampled only while ready=1
//  we      in   1         1 = store, 0 = load; captured at accept
//  addr    in   ADDR_W    word address; captured at accept
//  be      in   DATA_W/8  byte-lane enables for stores; bit i covers wdata[8i+7:8i]
//  wdata   in   DATA_W    store data; captured at accept
//  ready   out  1         port idle; can accept a request this cycle
//  rvalid  out  1         one-cycle response pulse, for both loads and stores
//  rdata   out  DATA_W    load data; valid when rvalid=1 and we was 0
//  err     out  1         qualified by rvalid; 1 = address >= DEPTH
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, ready=1, rvalid=0, rdata=0, err=0, wait counter=0.
//    Array contents are not reset.
//  - Accept: req && ready at a rising edge. Latch we/addr/be/wdata and load the counter
//    with WAIT_STATES. No request queue: req while ready=0 is ignored.
//  - FSM
//      IDLE -> WAIT  on accept, if WAIT_STATES>0
//      IDLE -> RESP  on accept, if WAIT_STATES==0 (access happens on the accept edge)
//      WAIT: decrement the counter each cycle. When the counter is 1, perform the access
//            and go to RESP.
//      RESP -> IDLE  unconditionally.
//  - ready = (state==IDLE). rvalid=1 only in RESP.
//  - Latency: accept at edge N -> rvalid high in cycle N+WAIT_STATES+1.
//    Throughput is 1 access per WAIT_STATES+2 cycles.
//  - Store: each byte lane with be[i]=1 is written; other lanes keep their contents.
//    be=0 still produces a response and changes nothing. rdata is unchanged on store responses.
//  - Load: rdata is registered from the array and holds until the next load response.
//  - Out of range (addr >= DEPTH): no array write; load returns rdata=0; err=1 in RESP.
//    err is 0 in every other cycle.
//  - Reset mid-operation: the latched request is discarded. A store still in WAIT never
//    reaches the array, and no rvalid is produced.
//  - The array is indexed by addr bits [clog2(DEPTH)-1:0] only after the range check passes.
// STRUCTURE
//  - Shared package risc16_pkg:
//      DMEM_DATA_W and DMEM_ADDR_W defaults.
//      FSM state typedef {IDLE, WAIT, RESP}.
//      Max WAIT_STATES constant (7).
//  - One sub-module, dmem_array_be: single-port synchronous RAM with per-byte write enables
//    and a registered read, parametrised by DATA_W and DEPTH. The FSM, counter, range
//    check and response registers stay in data_mem_hs.
// TESTING (defaults unless stated)
//  1. Store addr=5, wdata=16'hABCD, be=2'b11; then load addr=5
//     -> load rvalid 2 cycles after accept, rdata=16'hABCD, err=0.
//  2. Lane write: addr=5 holds 16'hABCD; store wdata=16'h0012, be=2'b01; then load
//     -> rdata=16'hAB12.
//  3. Load addr=1024 (=DEPTH) -> rvalid with err=1, rdata=16'h0000.
//     Store 16'hFFFF to addr=1024 -> err=1, and a read of addr=0 is unchanged.
//  4. req held high for 3 loads -> ready low in WAIT and RESP.
//     Accepts occur every 3 cycles, one rvalid per accept.
//  5. Assert rst_n=0 in WAIT of a store to addr=7 (old value 16'h1111)
//     -> rvalid never pulses, ready=1 after reset, addr=7 still reads 16'h1111.
//  6. WAIT_STATES=0 -> rvalid in the cycle right after accept. WAIT_STATES=7 -> rvalid 8 cycles
//     after accept.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared RISC-16 types and defaults for the handshaked data-memory port.
package risc16_pkg;

    localparam int DMEM_DATA_W   = 16;
    localparam int DMEM_ADDR_W   = 16;
    localparam int DMEM_DEPTH    = 1024;
    localparam int DMEM_MAX_WAIT = 7;
    localparam int DMEM_CNT_W    = $clog2(DMEM_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Index width of the array; a one-word array still needs a one-bit index.
    function automatic int dmem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module dmem_array_be
    import risc16_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = dmem_idx_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                we_i,
    input  logic                clr_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write into the storage array (contents are deliberately not reset)
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register: holds between loads, cleared for an out-of-range load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (clr_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_hs.sv
// Request/response data memory: wait-state FSM, range check and response registers
// wrapped around a byte-enabled synchronous array.
module data_mem_hs
    import risc16_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int                    NB      = DATA_W / 8;
    localparam int                    IDX_W   = dmem_idx_w(DEPTH);
    localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] WS_L    = DMEM_CNT_W'(WAIT_STATES);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [NB-1:0]         be_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  accept_s;
    logic                  access_s;
    logic                  acc_we_s;
    logic [ADDR_W-1:0]     acc_addr_s;
    logic [NB-1:0]         acc_be_s;
    logic [DATA_W-1:0]     acc_wdata_s;
    logic                  oor_s;

    assign accept_s = req && ready_q;

    // Next-state, wait counter and access strobe
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cnt_d = WS_L;
                    if (WS_L == {DMEM_CNT_W{1'b0}}) begin
                        state_d  = RESP;
                        access_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - {{(DMEM_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(DMEM_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d  = RESP;
                    access_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {DMEM_CNT_W{1'b0}};
            end
        endcase
    end

    // With zero wait states the access happens on the accept edge, before the latch
    always_comb begin
        if (state_q == IDLE) begin
            acc_we_s    = we;
            acc_addr_s  = addr;
            acc_be_s    = be;
            acc_wdata_s = wdata;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_be_s    = be_q;
            acc_wdata_s = wdata_q;
        end
    end

    // Range check and response flags for the cycle after the access
    always_comb begin
        oor_s    = ({1'b0, acc_addr_s} >= DEPTH_L);
        err_d    = access_s && oor_s;
        rvalid_d = access_s;
        ready_d  = (state_d == IDLE);
    end

    // FSM, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {DMEM_CNT_W{1'b0}};
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            be_q    <= {NB{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            we_q    <= we;
            addr_q  <= addr;
            be_q    <= be;
            wdata_q <= wdata;
        end
    end

    dmem_array_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (access_s && !oor_s),
        .we_i    (acc_we_s),
        .clr_i   (access_s && oor_s && !acc_we_s),
        .idx_i   (acc_addr_s[IDX_W-1:0]),
        .be_i    (acc_be_s),
        .wdata_i (acc_wdata_s),
        .rdata_o (rdata)
    );

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: instance 0 uses WAIT_STATES=1, instance 1 uses 0,
// instance 2 uses 7.
module tb_data_mem_hs;

    logic        clk;
    logic        rst_n;
    logic        req_a    [3];
    logic        we_a     [3];
    logic [15:0] addr_a   [3];
    logic [1:0]  be_a     [3];
    logic [15:0] wdata_a  [3];
    logic        ready_a  [3];
    logic        rvalid_a [3];
    logic [15:0] rdata_a  [3];
    logic        err_a    [3];

    int n_checks;
    int n_pass;

    data_mem_hs #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .be(be_a[0]), .wdata(wdata_a[0]), .ready(ready_a[0]), .rvalid(rvalid_a[0]),
        .rdata(rdata_a[0]), .err(err_a[0])
    );

    data_mem_hs #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst_n(rst_n), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .be(be_a[1]), .wdata(wdata_a[1]), .ready(ready_a[1]), .rvalid(rvalid_a[1]),
        .rdata(rdata_a[1]), .err(err_a[1])
    );

    data_mem_hs #(.WAIT_STATES(7)) dut_ws7 (
        .clk(clk), .rst_n(rst_n), .req(req_a[2]), .we(we_a[2]), .addr(addr_a[2]),
        .be(be_a[2]), .wdata(wdata_a[2]), .ready(ready_a[2]), .rvalid(rvalid_a[2]),
        .rdata(rdata_a[2]), .err(err_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete access on instance k; starts and ends 1 time unit after a rising edge.
    task automatic access(input int k, input string tag, input logic w, input logic [15:0] a,
                          input logic [1:0] b, input logic [15:0] d, input int exp_lat,
                          input logic [15:0] exp_rd, input logic exp_err);
        int n;
        chk({tag, "_ready"}, {31'd0, ready_a[k]}, 32'd1);
        req_a[k]   = 1'b1;
        we_a[k]    = w;
        addr_a[k]  = a;
        be_a[k]    = b;
        wdata_a[k] = d;
        @(posedge clk); #1;
        req_a[k]   = 1'b0;
        we_a[k]    = ~w;
        addr_a[k]  = ~a;
        be_a[k]    = ~b;
        wdata_a[k] = ~d;
        n = 1;
        while (rvalid_a[k] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"},   n, exp_lat);
        chk({tag, "_err"},   {31'd0, err_a[k]}, {31'd0, exp_err});
        chk({tag, "_rdata"}, {16'd0, rdata_a[k]}, {16'd0, exp_rd});
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, rvalid_a[k]}, 32'd0);
        chk({tag, "_errclr"}, {31'd0, err_a[k]}, 32'd0);
    endtask

    logic [8:0]  rdy_bits;
    logic [8:0]  rv_bits;
    logic [15:0] last_rd;
    logic        seen_rv;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_a[k]   = 1'b0;
            we_a[k]    = 1'b0;
            addr_a[k]  = 16'h0000;
            be_a[k]    = 2'b00;
            wdata_a[k] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, ready_a[0]},  32'd1);
        chk("rst_rvalid", {31'd0, rvalid_a[0]}, 32'd0);
        chk("rst_rdata",  {16'd0, rdata_a[0]},  32'd0);
        chk("rst_err",    {31'd0, err_a[0]},    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic store/load with one wait state
        access(0, "st0",   1'b1, 16'd0,    2'b11, 16'h5A5A, 2, 16'h0000, 1'b0);
        access(0, "st5",   1'b1, 16'd5,    2'b11, 16'hABCD, 2, 16'h0000, 1'b0);
        access(0, "ld5",   1'b0, 16'd5,    2'b11, 16'h0000, 2, 16'hABCD, 1'b0);
        // Lane write keeps the upper byte; store response leaves rdata alone
        access(0, "st5lo", 1'b1, 16'd5,    2'b01, 16'h0012, 2, 16'hABCD, 1'b0);
        access(0, "ld5lo", 1'b0, 16'd5,    2'b11, 16'h0000, 2, 16'hAB12, 1'b0);
        access(0, "st5be0",1'b1, 16'd5,    2'b00, 16'hFFFF, 2, 16'hAB12, 1'b0);
        access(0, "ld5be0",1'b0, 16'd5,    2'b11, 16'h0000, 2, 16'hAB12, 1'b0);
        // Range boundaries
        access(0, "ldoor", 1'b0, 16'd1024, 2'b11, 16'h0000, 2, 16'h0000, 1'b1);
        access(0, "stoor", 1'b1, 16'd1024, 2'b11, 16'hFFFF, 2, 16'h0000, 1'b1);
        access(0, "ld0",   1'b0, 16'd0,    2'b11, 16'h0000, 2, 16'h5A5A, 1'b0);
        access(0, "ldmax", 1'b0, 16'hFFFF, 2'b11, 16'h0000, 2, 16'h0000, 1'b1);
        access(0, "st1023",1'b1, 16'd1023, 2'b11, 16'h0F0F, 2, 16'h0000, 1'b0);
        access(0, "ld1023",1'b0, 16'd1023, 2'b11, 16'h0000, 2, 16'h0F0F, 1'b0);

        // req held high: accepts every third edge, one response per accept
        req_a[0]  = 1'b1;
        we_a[0]   = 1'b0;
        addr_a[0] = 16'd5;
        be_a[0]   = 2'b11;
        last_rd   = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            rdy_bits[i] = ready_a[0];
            rv_bits[i]  = rvalid_a[0];
            if (rvalid_a[0]) begin
                last_rd = rdata_a[0];
            end
            if (i == 6) begin
                req_a[0] = 1'b0;
            end
        end
        chk("burst_ready",  {23'd0, rdy_bits}, {23'd0, 9'b100100100});
        chk("burst_rvalid", {23'd0, rv_bits},  {23'd0, 9'b010010010});
        chk("burst_rdata",  {16'd0, last_rd},  {16'd0, 16'hAB12});

        // Reset during the wait state of a store discards it
        access(0, "st7",   1'b1, 16'd7, 2'b11, 16'h1111, 2, 16'hAB12, 1'b0);
        req_a[0]   = 1'b1;
        we_a[0]    = 1'b1;
        addr_a[0]  = 16'd7;
        be_a[0]    = 2'b11;
        wdata_a[0] = 16'h2222;
        @(posedge clk); #1;
        req_a[0] = 1'b0;
        chk("mid_inwait", {31'd0, ready_a[0]}, 32'd0);
        rst_n   = 1'b0;
        seen_rv = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready_a[0]}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rvalid_a[0]) begin
                seen_rv = 1'b1;
            end
            if (i == 2) begin
                rst_n = 1'b1;
            end
        end
        chk("mid_no_rvalid", {31'd0, seen_rv}, 32'd0);
        chk("mid_ready",     {31'd0, ready_a[0]}, 32'd1);
        chk("mid_rdata",     {16'd0, rdata_a[0]}, 32'd0);
        access(0, "ld7", 1'b0, 16'd7, 2'b11, 16'h0000, 2, 16'h1111, 1'b0);

        // Wait-state extremes
        access(1, "w0st", 1'b1, 16'd3, 2'b11, 16'h1234, 1, 16'h0000, 1'b0);
        access(1, "w0ld", 1'b0, 16'd3, 2'b11, 16'h0000, 1, 16'h1234, 1'b0);
        access(2, "w7st", 1'b1, 16'd9, 2'b11, 16'hBEEF, 8, 16'h0000, 1'b0);
        access(2, "w7ld", 1'b0, 16'd9, 2'b11, 16'h0000, 8, 16'hBEEF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
